instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the main controller decode: turns ALU-op-coded requests plus register fields into 32-bit MIPS words.
//  Sits between the test/program sequencer and the instruction memory write port / fetch stage.
//  Buffers encoded words in a small FIFO with valid/ready on both sides.
//  Reports requests that have no encoding.
// PARAMETERS
//  DEPTH    4   FIFO entries; power of two, >= 2
//  CNT_W    8   width of the illegal-request counter (only used with INSTR_ENC_ERRCNT_EN)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request present
//  in_ready   out  1      request can be accepted this cycle
//  in_alu_op  in   4      operation code, same coding as the controller's ALUOp (table below)
//  in_rs      in   5      source register 1
//  in_rt      in   5      source register 2 / I-type destination
//  in_rd      in   5      R-type destination
//  in_shamt   in   5      shift/rotate amount
//  in_imm     in   16     immediate (ADDI only)
//  out_valid  out  1      encoded word available
//  out_ready  in   1      consumer takes word this cycle
//  out_instr  out  32     encoded instruction
//  err        out  1      one-cycle pulse: illegal in_alu_op accepted
//  err_count  out  CNT_W  saturating count of illegal requests
// BEHAVIOUR
//  Encoding (op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] func[5:0]):
//   0000 ADD op=000000 f=100000 | 0001 SUB f=100010 | 0011 AND f=100100 | 0100 OR f=100101
//   0101 SLT f=101010 | 1000 SLL f=000000, rs=0 | 1001 SRL f=000010, rs=0
//   1011 CLO op=011100 f=100001 | 1100 CLZ op=011100 f=100000 | 0010 MUL op=011100 f=000010
//   1010 ROT op=011100 f=000110, rs=0 | 0110 ADDI op=001000 {rs,rt,imm16}
//   shamt field forced to 0 except SLL/SRL/ROT. Codes 0111, 1101, 1110, 1111 are illegal.
//  Accept on in_valid && in_ready; in_ready = !full (no bypass; a pop in the same cycle does not free the slot).
//  Legal request: encoded combinationally, written to FIFO at the accepting edge; out_valid no earlier than next cycle.
//  Illegal request: consumed (in_ready honoured), not enqueued; err=1 for exactly the following cycle.
//  Output: out_instr = head entry while out_valid; pop on out_valid && out_ready; out_instr holds when stalled.
//  Order preserved; wr/rd pointers wrap modulo DEPTH; occupancy counter 0..DEPTH.
//  Push and pop in the same cycle when neither full nor empty: occupancy unchanged.
//  Empty: out_valid=0, out_instr=0.
//  Reset (async, any time, including mid-transfer): FIFO flushed.
//   Reset values: in_ready=1, out_valid=0, out_instr=0, err=0, err_count=0.
// CONFIGURATION
//  INSTR_ENC_ERRCNT_EN defined: err_count increments on every illegal accept and saturates at all-ones.
//  INSTR_ENC_ERRCNT_EN undefined: err_count tied to 0 and no counter logic is built. err is unaffected either way.
// STRUCTURE
//  Shared package instr_enc_pkg holds:
//   - ALU-op code localparams (shared with the controller)
//   - OPC_RTYPE/OPC_SPECIAL2/OPC_ADDI
//   - FUNCT_* constants
//  Sub-module instr_enc_fifo: DEPTH x 32 synchronous FIFO with full/empty.
//  Top level holds the encode function, handshake and error logic.
// TESTING
//  ADD rs=1 rt=2 rd=3 -> out_instr=32'h00221820 on the cycle after accept.
//  ADDI rs=4 rt=5 imm=16'hFFFF -> 32'h2085FFFF; SLL rt=2 rd=3 shamt=4 -> 32'h00021900.
//  Push DEPTH+1 requests with out_ready=0 -> in_ready=0 after DEPTH pushes; drain gives the same order.
//  in_alu_op=4'b1111 -> nothing enqueued, err pulses 1 cycle; with macro, err_count saturates at 255 after 300 illegal requests.
//  rst_n low while FIFO holds 3 entries -> out_valid=0 and in_ready=1 immediately; no stale word after release.
//  Full FIFO with push and pop in the same cycle -> pop occurs, push refused (in_ready=0), count = DEPTH-1.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared encoding constants for the instruction encoder.
// ALU-op codes match the controller decode; opcode/funct per MIPS.
package instr_enc_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_ADDI = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_ROT  = 4'b1010;
  localparam logic [3:0] ALU_CLO  = 4'b1011;
  localparam logic [3:0] ALU_CLZ  = 4'b1100;

  localparam logic [5:0] OPC_RTYPE    = 6'b000000;
  localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OPC_ADDI     = 6'b001000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_SLL = 6'b000000;
  localparam logic [5:0] FUNCT_SRL = 6'b000010;
  localparam logic [5:0] FUNCT_CLO = 6'b100001;
  localparam logic [5:0] FUNCT_CLZ = 6'b100000;
  localparam logic [5:0] FUNCT_MUL = 6'b000010;
  localparam logic [5:0] FUNCT_ROT = 6'b000110;

endpackage

// File: rtl/instr_enc_fifo.sv
// DEPTH x W synchronous FIFO; rdData reads 0 when empty.
// Ports: push/wrData in, pop in, rdData out, full/empty out.
module instr_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wrData,
  input  logic         pop,
  output logic [W-1:0] rdData,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [CW-1:0] cnt;
  logic          doPush;
  logic          doPop;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rdData = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wrData;
  end

  // power-of-two depth: pointers wrap by overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      cnt   <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      unique case ({doPush, doPop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes ALU-op requests into MIPS words, buffered in a FIFO.
// Ports: in_* request (valid/ready), out_* word (valid/ready),
// err pulse and err_count (counter built with INSTR_ENC_ERRCNT_EN).
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_alu_op,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_shamt,
  input  logic [15:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  function automatic logic [31:0] pack(
    input logic [5:0] opc,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] sh,
    input logic [5:0] fn
  );
    return {opc, rs, rt, rd, sh, fn};
  endfunction

  logic [31:0] encWord;
  logic        encOk;
  logic        accept;
  logic        illegalAcc;
  logic        full;
  logic        empty;

  always_comb begin
    encWord = '0;
    encOk   = 1'b1;
    unique case (in_alu_op)
      ALU_ADD:  encWord = pack(OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FUNCT_ADD);
      ALU_SUB:  encWord = pack(OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FUNCT_SUB);
      ALU_AND:  encWord = pack(OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FUNCT_AND);
      ALU_OR:   encWord = pack(OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FUNCT_OR);
      ALU_SLT:  encWord = pack(OPC_RTYPE, in_rs, in_rt, in_rd, 5'd0, FUNCT_SLT);
      ALU_SLL:  encWord = pack(OPC_RTYPE, 5'd0, in_rt, in_rd, in_shamt, FUNCT_SLL);
      ALU_SRL:  encWord = pack(OPC_RTYPE, 5'd0, in_rt, in_rd, in_shamt, FUNCT_SRL);
      ALU_CLO:  encWord = pack(OPC_SPECIAL2, in_rs, in_rt, in_rd, 5'd0, FUNCT_CLO);
      ALU_CLZ:  encWord = pack(OPC_SPECIAL2, in_rs, in_rt, in_rd, 5'd0, FUNCT_CLZ);
      ALU_MUL:  encWord = pack(OPC_SPECIAL2, in_rs, in_rt, in_rd, 5'd0, FUNCT_MUL);
      ALU_ROT:  encWord = pack(OPC_SPECIAL2, 5'd0, in_rt, in_rd, in_shamt, FUNCT_ROT);
      ALU_ADDI: encWord = {OPC_ADDI, in_rs, in_rt, in_imm};
      default:  encOk   = 1'b0;
    endcase
  end

  assign in_ready   = !full;
  assign accept     = in_valid && in_ready;
  assign illegalAcc = accept && !encOk;
  assign out_valid  = !empty;

  instr_enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) uFifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (accept && encOk),
    .wrData (encWord),
    .pop    (out_ready),
    .rdData (out_instr),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= illegalAcc;
  end

`ifdef INSTR_ENC_ERRCNT_EN
  logic [CNT_W-1:0] errCnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errCnt <= '0;
    end else if (illegalAcc && errCnt != '1) begin
      errCnt <= errCnt + CNT_W'(1);
    end
  end

  assign err_count = errCnt;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with a queue-based model.
// Directed cases pin literal encodings, full, illegal and reset.
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_alu_op;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [4:0]       in_shamt;
  logic [15:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             err;
  logic [CNT_W-1:0] err_count;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_alu_op (in_alu_op),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 0;

  logic [31:0] q[$];
  bit          errExp;
  int          errCntExp;
  longint      mw;
  bit          mAcc;
  bit          mPop;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Field-weighted sum; returns -1 for codes with no encoding.
  function automatic longint modelEnc(int op, int rs, int rt, int rd,
                                      int sh, int imm);
    longint opc = 0;
    longint fn = 0;
    bit shiftForm = 0;
    case (op)
      0:  fn = 32;
      1:  fn = 34;
      3:  fn = 36;
      4:  fn = 37;
      5:  fn = 42;
      8:  begin fn = 0; shiftForm = 1; end
      9:  begin fn = 2; shiftForm = 1; end
      11: begin opc = 28; fn = 33; end
      12: begin opc = 28; fn = 32; end
      2:  begin opc = 28; fn = 2; end
      10: begin opc = 28; fn = 6; shiftForm = 1; end
      6:  return 8 * 2**26 + rs * 2**21 + rt * 2**16 + imm;
      default: return -1;
    endcase
    if (shiftForm)
      return opc * 2**26 + rt * 2**16 + rd * 2**11 + sh * 64 + fn;
    return opc * 2**26 + rs * 2**21 + rt * 2**16 + rd * 2**11 + fn;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      errExp    = 0;
      errCntExp = 0;
    end else begin
      mw   = modelEnc(in_alu_op, in_rs, in_rt, in_rd, in_shamt, in_imm);
      mAcc = in_valid && (q.size() < DEPTH);
      mPop = out_ready && (q.size() > 0);
      if (mPop) void'(q.pop_front());
      if (mAcc && mw >= 0) q.push_back(mw[31:0]);
      errExp = mAcc && (mw < 0);
      if (errExp && errCntExp < 255) errCntExp++;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("out_valid", 32'(out_valid), 32'(q.size() > 0));
      check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      check("out_instr", out_instr, (q.size() > 0) ? q[0] : 32'h0);
      check("err", 32'(err), 32'(errExp));
`ifdef INSTR_ENC_ERRCNT_EN
      check("err_count", 32'(err_count), 32'(errCntExp));
`else
      check("err_count", 32'(err_count), 32'h0);
`endif
    end
  end

  int legal[12] = '{0, 1, 2, 3, 4, 5, 6, 8, 9, 10, 11, 12};
  int bad[4]    = '{7, 13, 14, 15};

  task automatic setReq(input bit v, input int op);
    in_valid  = v;
    in_alu_op = 4'(op);
    in_rs     = 5'($urandom);
    in_rt     = 5'($urandom);
    in_rd     = 5'($urandom);
    in_shamt  = 5'($urandom);
    in_imm    = 16'($urandom);
  endtask

  task automatic setFields(input int op, input int rs, input int rt,
                           input int rd, input int sh, input int imm);
    in_valid  = 1'b1;
    in_alu_op = 4'(op);
    in_rs     = 5'(rs);
    in_rt     = 5'(rt);
    in_rd     = 5'(rd);
    in_shamt  = 5'(sh);
    in_imm    = 16'(imm);
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b0;
    setReq(0, 0);
    repeat (2) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'h1);
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_instr", out_instr, 32'h0);
    check("rst err", 32'(err), 32'h0);
    check("rst err_count", 32'(err_count), 32'h0);
    rst_n = 1'b1;
    chkEn = 1;

    // literal encodings
    setFields(0, 1, 2, 3, 7, 16'h1234);
    @(negedge clk);
    check("lit ADD", out_instr, 32'h00221820);
    out_ready = 1'b1;
    setFields(6, 4, 5, 9, 3, 16'hFFFF);
    @(negedge clk);
    check("lit ADDI", out_instr, 32'h2085FFFF);
    setFields(8, 17, 2, 3, 4, 0);
    @(negedge clk);
    check("lit SLL", out_instr, 32'h00021900);
    setReq(0, 0);
    repeat (2) @(negedge clk);

    // fill, then push+pop on full
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      setReq(1, legal[$urandom_range(11)]);
      @(negedge clk);
    end
    check("full in_ready", 32'(in_ready), 32'h0);
    setReq(1, legal[$urandom_range(11)]);
    out_ready = 1'b1;
    @(negedge clk);
    check("full pop in_ready", 32'(in_ready), 32'h1);
    check("full pop out_valid", 32'(out_valid), 32'h1);
    setReq(0, 0);
    repeat (DEPTH + 1) @(negedge clk);

    // illegal request
    setReq(1, 15);
    @(negedge clk);
    setReq(0, 0);
    check("ill err", 32'(err), 32'h1);
    check("ill out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("ill err end", 32'(err), 32'h0);
    for (int i = 0; i < 300; i++) begin
      setReq(1, bad[$urandom_range(3)]);
      @(negedge clk);
    end
    setReq(0, 0);
    @(negedge clk);
`ifdef INSTR_ENC_ERRCNT_EN
    check("errcnt sat", 32'(err_count), 32'd255);
`else
    check("errcnt off", 32'(err_count), 32'd0);
`endif

    // reset while holding 3 entries
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      setReq(1, legal[$urandom_range(11)]);
      @(negedge clk);
    end
    setReq(0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst out_valid", 32'(out_valid), 32'h0);
    check("arst in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post rst out_valid", 32'(out_valid), 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0)
        setReq(1, bad[$urandom_range(3)]);
      else
        setReq($urandom_range(3) != 0, legal[$urandom_range(11)]);
      out_ready = ($urandom_range(2) != 0);
      @(negedge clk);
    end
    setReq(0, 0);
    out_ready = 1'b1;
    repeat (DEPTH + 2) @(negedge clk);
    check("drained", 32'(out_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
